// File: rtl/div_sequencer.sv
// div_sequencer: drives a multi-cycle divider for div/divu in the execute stage.
// Optional `DIV_ZERO_BYPASS_EN: zero divisors complete without using the engine.
module div_sequencer #(
   parameter int unsigned TIMEOUT = 40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        div_req,
   input  logic        div_signed,
   input  logic [31:0] opa,
   input  logic [31:0] opb,
   input  logic        cancel,
   input  logic        pipe_hold,
   output logic        div_start,
   output logic        div_signed_o,
   output logic [31:0] div_opa,
   output logic [31:0] div_opb,
   output logic        div_annul,
   input  logic        div_ready,
   input  logic [63:0] div_result,
   output logic        stall_div,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        result_valid,
   output logic        div_error
);
   typedef enum logic [1:0] {IDLE, BUSY, DRAIN, DONE} state_t;

   localparam logic [5:0] TMO_LAST = 6'(TIMEOUT - 1);

   state_t     state;
   logic [5:0] cnt;
   logic       accept;

   assign accept = (state == IDLE) && div_req && !cancel;

   always_comb begin
      stall_div    = 1'b0;
      result_valid = 1'b0;
      case (state)
         IDLE, DRAIN: stall_div    = div_req;
         BUSY:        stall_div    = 1'b1;
         DONE:        result_valid = ~cancel;
         default:     ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         hi           <= '0;
         lo           <= '0;
         div_opa      <= '0;
         div_opb      <= '0;
         div_signed_o <= 1'b0;
         div_start    <= 1'b0;
         div_annul    <= 1'b0;
         div_error    <= 1'b0;
      end else begin
         div_start <= 1'b0;
         div_annul <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  div_opa      <= opa;
                  div_opb      <= opb;
                  div_signed_o <= div_signed;
                  cnt          <= '0;
`ifdef DIV_ZERO_BYPASS_EN
                  if (opb == '0) begin
                     hi    <= opa;
                     lo    <= '1;
                     state <= DONE;
                  end else begin
                     div_start <= 1'b1;
                     state     <= BUSY;
                  end
`else
                  div_start <= 1'b1;
                  state     <= BUSY;
`endif
               end
            end
            BUSY: begin
               cnt <= cnt + 6'd1;
               // cancel beats ready; a ready arriving on the last allowed cycle still completes
               if (cancel) begin
                  div_annul <= 1'b1;
                  state     <= div_ready ? IDLE : DRAIN;
               end else if (div_ready) begin
                  hi    <= div_result[63:32];
                  lo    <= div_result[31:0];
                  state <= DONE;
               end else if (cnt == TMO_LAST) begin
                  div_annul <= 1'b1;
                  div_error <= 1'b1;
                  state     <= IDLE;
               end
            end
            DRAIN: begin
               if (div_ready) state <= IDLE;
            end
            DONE: begin
               if (!(pipe_hold && !cancel)) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer; the divider engine is played by the bench.
module tb_div_sequencer;
   logic        clk, rst, div_req, div_signed, cancel, pipe_hold, div_ready;
   logic [31:0] opa, opb;
   logic [63:0] div_result;
   logic        div_start, div_signed_o, div_annul, stall_div, result_valid, div_error;
   logic [31:0] div_opa, div_opb, hi, lo;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_hi, exp_lo;

   div_sequencer #(.TIMEOUT(40)) dut (
      .clk(clk), .rst(rst), .div_req(div_req), .div_signed(div_signed),
      .opa(opa), .opb(opb), .cancel(cancel), .pipe_hold(pipe_hold),
      .div_start(div_start), .div_signed_o(div_signed_o), .div_opa(div_opa),
      .div_opb(div_opb), .div_annul(div_annul), .div_ready(div_ready),
      .div_result(div_result), .stall_div(stall_div), .hi(hi), .lo(lo),
      .result_valid(result_valid), .div_error(div_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full division: accept, n BUSY cycles with ready on the n-th, then hold+1 DONE cycles.
   task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input int n, input logic [63:0] res, input int hold);
      int stalls;
      step();
      div_req = 1'b1; div_signed = sgn; opa = a; opb = b;
      div_ready = 1'b0; cancel = 1'b0; pipe_hold = 1'b0;
      #1;
      stalls = stall_div ? 1 : 0;
      for (int k = 1; k <= n; k++) begin
         step();
         div_ready  = (k == n);
         div_result = (k == n) ? res : 64'hDEAD_BEEF_0BAD_F00D;
         #1;
         if (stall_div) stalls++;
         if (k == 1) chk("start_first", div_start, 1'b1);
         if (k == 2) chk("start_pulse", div_start, 1'b0);
         if (k == n) begin
            chk("opa_hold", div_opa, a);
            chk("opb_hold", div_opb, b);
            chk("signed_o", div_signed_o, sgn);
            chk("busy_no_valid", result_valid, 1'b0);
         end
      end
      chk("stall_cycles", 64'(stalls), 64'(n + 1));
      for (int h = 0; h <= hold; h++) begin
         step();
         div_ready = 1'b0; div_req = (h == hold); pipe_hold = (h < hold);
         #1;
         chk("done_valid", result_valid, 1'b1);
         chk("done_hi", hi, res[63:32]);
         chk("done_lo", lo, res[31:0]);
         chk("done_stall", stall_div, 1'b0);
         chk("done_no_start", div_start, 1'b0);
      end
      pipe_hold = 1'b0;
      step();
      #1;
      chk("idle_valid", result_valid, 1'b0);
      chk("idle_no_reaccept", div_start, 1'b0);
      chk("idle_req_stall", stall_div, 1'b1);
      div_req = 1'b0;
      #1;
      exp_hi = res[63:32];
      exp_lo = res[31:0];
   endtask

   initial begin
      rst = 1'b1; div_req = 1'b0; div_signed = 1'b0; opa = '0; opb = '0;
      cancel = 1'b0; pipe_hold = 1'b0; div_ready = 1'b0; div_result = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_opa", div_opa, 32'd0);
      chk("rst_start", div_start, 1'b0);
      chk("rst_annul", div_annul, 1'b0);
      chk("rst_valid", result_valid, 1'b0);
      chk("rst_error", div_error, 1'b0);
      chk("rst_stall", stall_div, 1'b0);
      rst = 1'b0;

      // divu 100/7: q=14 r=2, ready on 33rd BUSY cycle
      do_div(32'd100, 32'd7, 1'b0, 33, {32'd2, 32'd14}, 0);
      // div -7/2: q=-3 r=-1
      do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 5, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
      // 50/6 with pipe_hold for 3 DONE cycles: q=8 r=2
      do_div(32'd50, 32'd6, 1'b0, 3, {32'd2, 32'd8}, 3);

      // cancel in 10th BUSY cycle, then follow-up request during DRAIN
      step();
      div_req = 1'b1; div_signed = 1'b0; opa = 32'd9; opb = 32'd3; #1;
      for (int k = 1; k <= 10; k++) begin
         step();
         cancel = (k == 10);
         if (k == 10) div_req = 1'b0;
         #1;
         if (k == 10) chk("cancel_busy_stall", stall_div, 1'b1);
      end
      step(); cancel = 1'b0; #1;
      chk("annul_pulse", div_annul, 1'b1);
      chk("drain_stall", stall_div, 1'b0);
      chk("drain_valid", result_valid, 1'b0);
      step(); div_req = 1'b1; opa = 32'd77; opb = 32'd7; #1;
      chk("annul_once", div_annul, 1'b0);
      chk("drain_req_stall", stall_div, 1'b1);
      step(); div_ready = 1'b1; div_result = 64'h1111_2222_3333_4444; #1;
      chk("drain_no_start", div_start, 1'b0);
      step(); div_ready = 1'b0; #1;
      chk("drain_exit_no_start", div_start, 1'b0);
      chk("drain_exit_stall", stall_div, 1'b1);
      chk("drain_ignores_hi", hi, exp_hi);
      chk("drain_ignores_lo", lo, exp_lo);
      step(); #1;
      chk("followup_start", div_start, 1'b1);
      chk("followup_opa", div_opa, 32'd77);
      step(); div_ready = 1'b1; div_result = {32'd0, 32'd11}; #1;
      step(); div_ready = 1'b0; div_req = 1'b0; #1;
      chk("followup_valid", result_valid, 1'b1);
      chk("followup_lo", lo, 32'd11);
      exp_hi = 32'd0; exp_lo = 32'd11;
      step(); #1;

      // cancel and ready together: straight to IDLE, no capture
      step(); div_req = 1'b1; opa = 32'd8; opb = 32'd2; #1;
      step(); #1;
      step(); cancel = 1'b1; div_ready = 1'b1; div_result = 64'hAAAA_AAAA_BBBB_BBBB; div_req = 1'b0; #1;
      step(); cancel = 1'b0; div_ready = 1'b0; #1;
      chk("cr_annul", div_annul, 1'b1);
      chk("cr_valid", result_valid, 1'b0);
      chk("cr_hi", hi, exp_hi);
      chk("cr_lo", lo, exp_lo);
      step(); #1;
      chk("cr_annul_clear", div_annul, 1'b0);
      chk("cr_idle_stall", stall_div, 1'b0);

      // timeout: no ready for 40 BUSY cycles
      step(); div_req = 1'b1; opa = 32'd1; opb = 32'd1; #1;
      for (int k = 1; k <= 40; k++) begin
         step(); #1;
         if (k == 40) begin
            chk("tmo_no_early_annul", div_annul, 1'b0);
            chk("tmo_no_early_error", div_error, 1'b0);
            chk("tmo_busy_stall", stall_div, 1'b1);
            div_req = 1'b0;
         end
      end
      step(); #1;
      chk("tmo_annul", div_annul, 1'b1);
      chk("tmo_error", div_error, 1'b1);
      chk("tmo_stall_release", stall_div, 1'b0);
      chk("tmo_hi", hi, exp_hi);
      chk("tmo_lo", lo, exp_lo);
      step(); #1;
      chk("tmo_annul_clear", div_annul, 1'b0);
      chk("tmo_error_sticky", div_error, 1'b1);

      // zero divisor
      step(); div_req = 1'b1; opa = 32'd5; opb = 32'd0; #1;
      step(); div_req = 1'b0; #1;
`ifdef DIV_ZERO_BYPASS_EN
      chk("bypass_valid", result_valid, 1'b1);
      chk("bypass_hi", hi, 32'd5);
      chk("bypass_lo", lo, 32'hFFFF_FFFF);
      chk("bypass_no_start", div_start, 1'b0);
      step(); #1;
`else
      chk("zero_start", div_start, 1'b1);
      chk("zero_opb", div_opb, 32'd0);
      chk("zero_busy_valid", result_valid, 1'b0);
      div_ready = 1'b1; div_result = {32'd5, 32'hFFFF_FFFF};
      step(); div_ready = 1'b0; #1;
      chk("zero_valid", result_valid, 1'b1);
      chk("zero_hi", hi, 32'd5);
      step(); #1;
`endif

      // reset mid-BUSY
      step(); div_req = 1'b1; opa = 32'd3; opb = 32'd1; #1;
      for (int k = 1; k <= 5; k++) step();
      rst = 1'b1; div_req = 1'b0;
      step(); rst = 1'b0; #1;
      chk("mrst_hi", hi, 32'd0);
      chk("mrst_lo", lo, 32'd0);
      chk("mrst_opa", div_opa, 32'd0);
      chk("mrst_error", div_error, 1'b0);
      chk("mrst_start", div_start, 1'b0);
      chk("mrst_stall", stall_div, 1'b0);
      step(); #1;
      chk("mrst_idle_stall", stall_div, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
